// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths and the writeback buffer entry type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREG = 32;
  typedef struct packed {
    logic [XLEN-1:0]       wd;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
  } wb_entry_t;
endpackage

// File: rtl/wb_skid_fifo.sv
// wb_skid_fifo: writeback buffer with head peek and age-ordered entry view
module wb_skid_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  wb_entry_t       din,
  output wb_entry_t       head,
  output logic [CW-1:0]   count,
  output wb_entry_t       ord [DEPTH],
  output logic [DEPTH-1:0] vis
);
  wb_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign head = mem[rd_ptr];
  // ord[0] is the oldest entry, ord[count-1] the youngest
  for (genvar i = 0; i < DEPTH; i++) begin : g_ord
    assign ord[i] = mem[PW'((32'(rd_ptr) + i) % DEPTH)];
    assign vis[i] = CW'(i) < count;
  end
endmodule

// File: rtl/writeback_regfile.sv
// writeback_regfile: buffered ALU writeback into a register file; WB_BYPASS_EN exposes buffered results on reads
module writeback_regfile
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int NREG = riscv_pkg::NREG,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_wd,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_we,
  input  logic                  wb_stall,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic                  retire_valid,
  output logic [REG_ADDR_W-1:0] retire_rd,
  output logic [1:0]            occupancy
);
`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam int CW = $clog2(DEPTH + 1);
  logic [XLEN-1:0] regs [NREG];
  logic [CW-1:0] count;
  wb_entry_t head;
  wb_entry_t ord [DEPTH];
  logic [DEPTH-1:0] vis;
  logic push;
  logic [REG_ADDR_W-1:0] ra [2];
  logic [XLEN-1:0] rdat [2];
  assign in_ready = count < CW'(DEPTH) && !rst;
  assign push = in_valid && in_ready;
  assign retire_valid = count != '0 && !wb_stall;
  assign retire_rd = retire_valid ? head.rd : '0;
  assign occupancy = 2'(count);
  wb_skid_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (retire_valid),
    .din   ('{wd: in_wd, rd: in_rd, we: in_we}),
    .head  (head),
    .count (count),
    .ord   (ord),
    .vis   (vis)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (retire_valid && head.we && head.rd != '0 && 32'(head.rd) < NREG) begin
      regs[head.rd] <= head.wd;
    end
  end
  assign ra[0] = rs1_addr;
  assign ra[1] = rs2_addr;
  // later (younger) buffered matches override earlier ones
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdat[p] = (ra[p] == '0 || 32'(ra[p]) >= NREG) ? '0 : regs[ra[p]];
      for (int i = 0; i < DEPTH; i++)
        if (BYPASS && vis[i] && ord[i].we && ord[i].rd == ra[p] && ra[p] != '0) rdat[p] = ord[i].wd;
    end
  end
  assign rs1_data = rdat[0];
  assign rs2_data = rdat[1];
endmodule
